// File: rtl/digit_serial_add3_if.sv
// Operand/result handshake bundle for digit_serial_add3.
// The optional sub line exists only when DIGIT_SERIAL_ADD3_SUB_EN is defined.
interface digit_serial_add3_if #(parameter int WIDTH = 12);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
  // A producer holds valid and its payload until that edge.
  // A consumer's ready never depends combinationally on valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef DIGIT_SERIAL_ADD3_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef DIGIT_SERIAL_ADD3_SUB_EN
    output sub,
`endif
    output in_valid, input in_ready, output a, output b,
    input out_valid, output out_ready, input sum, input cout
  );

  modport slave (
`ifdef DIGIT_SERIAL_ADD3_SUB_EN
    input sub,
`endif
    input in_valid, output in_ready, input a, input b,
    output out_valid, input out_ready, output sum, output cout
  );
endinterface

// File: rtl/digit_serial_add3.sv
// Digit-serial adder: WIDTH-bit sum produced 3 bits per clock through one FA-based slice.
// Optional subtract mode is enabled by defining DIGIT_SERIAL_ADD3_SUB_EN.
module digit_serial_add3 #(
  parameter int WIDTH = 12
) (
  input  logic                clk,
  input  logic                rst,
  digit_serial_add3_if.slave  bus,
  output logic [1:0]          state_dbg
);
  localparam int N  = WIDTH / 3;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % 3) != 0 || WIDTH < 3) begin : g_bad_width
    $error("digit_serial_add3: WIDTH must be a multiple of 3 and at least 3");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             carry, cout_r;
  logic [CW-1:0]    cnt;
  logic [2:0]       b_dig, slice_sum;
  logic             c1, c2, slice_cout;
  logic             accept, release_out, last_digit;

  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    fa = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

`ifdef DIGIT_SERIAL_ADD3_SUB_EN
  logic sub_r;
  // Subtraction is a + ~b + 1: invert b digits, seed carry with 1 at accept.
  assign b_dig = b_sh[2:0] ^ {3{sub_r}};
`else
  assign b_dig = b_sh[2:0];
`endif

  assign {c1,         slice_sum[0]} = fa(a_sh[0], b_dig[0], carry);
  assign {c2,         slice_sum[1]} = fa(a_sh[1], b_dig[1], c1);
  assign {slice_cout, slice_sum[2]} = fa(a_sh[2], b_dig[2], c2);

  assign accept      = bus.in_valid & (state == S_IDLE);
  assign release_out = bus.out_ready & (state == S_DONE);
  assign last_digit  = (state == S_RUN) && (cnt == LAST);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_RUN;
      S_RUN:   if (last_digit) state_next = S_DONE;
      S_DONE:  if (release_out) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
`ifdef DIGIT_SERIAL_ADD3_SUB_EN
      sub_r  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      res    <= '0;
      cout_r <= 1'b0;
      cnt    <= '0;
`ifdef DIGIT_SERIAL_ADD3_SUB_EN
      sub_r  <= bus.sub;
      carry  <= bus.sub;
`else
      carry  <= 1'b0;
`endif
    end else if (state == S_RUN) begin
      a_sh  <= a_sh >> 3;
      b_sh  <= b_sh >> 3;
      // New digit enters at the top, so after N digits digit 0 sits at the LSBs.
      res   <= WIDTH'({slice_sum, res} >> 3);
      carry <= slice_cout;
      cnt   <= cnt + 1'b1;
      if (last_digit) cout_r <= slice_cout;
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.sum       = res;
  assign bus.cout      = cout_r;
  assign state_dbg     = state;
endmodule

// File: tb/tb_digit_serial_add3.sv
// Directed bench for digit_serial_add3 (WIDTH=12): scoreboard queue of {cout,sum},
// handshake hold, mid-run reset and back-to-back throughput.
module tb_digit_serial_add3;
  localparam int W = 12;
  localparam int N = W / 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] state_dbg;
  int tests = 0;
  int fails = 0;
  logic [W:0] exp_q[$];

  digit_serial_add3_if #(.WIDTH(W)) bus ();

  digit_serial_add3 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    if (sv) model = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
    else    model = {1'b0, av} + {1'b0, bv};
  endfunction

  task automatic drive_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    bus.a = av;
    bus.b = bv;
`ifdef DIGIT_SERIAL_ADD3_SUB_EN
    bus.sub = sv;
`endif
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    int ok = 0;
    drive_op(av, bv, sv);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 40 && ok == 0; k++) begin
      if (bus.in_ready) begin
        exp_q.push_back(model(av, bv, sv));
        ok = 1;
      end
      @(posedge clk); @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("accept_seen", 32'(ok), 32'd1);
  endtask

  task automatic compare_out(input string tag);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, 32'(bus.sum), 32'(e[W-1:0]));
      check({tag, "_cout"}, 32'(bus.cout), 32'(e[W]));
    end
  endtask

  // Waits for out_valid, counting edges since the accept edge, then completes the handshake.
  task automatic recv(input string tag, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    compare_out(tag);
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int cyc, ai, ri;
    int t_out[3];
    logic [W-1:0] op_a[3];
    logic [W-1:0] op_b[3];

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive_op('0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Basic add with latency
    send(12'h123, 12'h456, 1'b0);
    recv("add_123_456", lat);
    check("latency", 32'(lat), 32'(N));

    // Carry ripples through every digit
    send(12'hFFF, 12'h001, 1'b0);
    recv("add_fff_001", lat);
    send(12'hFFF, 12'hFFF, 1'b0);
    recv("add_fff_fff", lat);
    send($urandom_range(0, 4095), $urandom_range(0, 4095), 1'b0);
    recv("add_random", lat);

    // Output held under backpressure while a new op waits
    send(12'h0AB, 12'h0CD, 1'b0);
    while (!bus.out_valid) begin @(posedge clk); @(negedge clk); end
    drive_op(12'h111, 12'h222, 1'b0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_sum", 32'(bus.sum), 32'h178);
      check("hold_cout", 32'(bus.cout), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    compare_out("hold_result");
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
    check("hold_release_idle", 32'(state_dbg), 32'd0);
    check("hold_release_in_ready", 32'(bus.in_ready), 32'd1);
    send(12'h111, 12'h222, 1'b0);
    recv("after_hold", lat);

    // Reset during the 2nd RUN cycle discards the operation
    send(12'h555, 12'h333, 1'b0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_sum", 32'(bus.sum), 32'd0);
    check("midrst_cout", 32'(bus.cout), 32'd0);
    send(12'h7FF, 12'h001, 1'b0);
    recv("add_7ff_001", lat);

    // Back-to-back with in_valid and out_ready held high
    op_a[0] = 12'h010; op_b[0] = 12'h020;
    op_a[1] = 12'hABC; op_b[1] = 12'h987;
    op_a[2] = 12'($urandom_range(0, 4095)); op_b[2] = 12'($urandom_range(0, 4095));
    drive_op(op_a[0], op_b[0], 1'b0);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    ai = 0; ri = 0; cyc = 0;
    while (ri < 3 && cyc < 80) begin
      logic acc;
      acc = bus.in_ready && (ai < 3);
      if (acc) exp_q.push_back(model(op_a[ai], op_b[ai], 1'b0));
      if (bus.out_valid) begin
        compare_out("b2b");
        if (ri < 3) t_out[ri] = cyc;
        ri++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
      if (acc) begin
        ai++;
        if (ai < 3) drive_op(op_a[ai], op_b[ai], 1'b0);
        else bus.in_valid = 1'b0;
      end
    end
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check("b2b_count", 32'(ri), 32'd3);
    check("b2b_gap1", 32'(t_out[1] - t_out[0]), 32'(N + 2));
    check("b2b_gap2", 32'(t_out[2] - t_out[1]), 32'(N + 2));
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef DIGIT_SERIAL_ADD3_SUB_EN
    send(12'h007, 12'h005, 1'b1);
    recv("sub_7_5", lat);
    check("sub_7_5_direct", 32'(model(12'h007, 12'h005, 1'b1)), 32'h1002);
    send(12'h005, 12'h007, 1'b1);
    recv("sub_5_7", lat);
    send(12'h123, 12'h456, 1'b0);
    recv("sub0_add", lat);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
